// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and arithmetic helpers for the convolution MAC engine
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FIN,
        OUT
    } state_t;

    localparam int DEF_N_CH   = 3;
    localparam int DEF_KERNEL = 9;
    localparam int DEF_N_FILT = 3;
    localparam int WIN_LEN    = DEF_N_CH * DEF_KERNEL;
    localparam int NW         = DEF_N_FILT * WIN_LEN;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Round half up at the binary point, then clamp to the signed data_w range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int frac,
                                                     input int data_w);
        logic signed [63:0] sum;
        logic signed [63:0] lim_hi;
        logic signed [63:0] lim_lo;
        sum = acc;
        if (frac > 0) begin
            sum = acc + (64'sd1 <<< (frac - 1));
        end
        sum    = sum >>> frac;
        lim_hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lim_lo = -(64'sd1 <<< (data_w - 1));
        if (sum > lim_hi) begin
            return lim_hi;
        end
        if (sum < lim_lo) begin
            return lim_lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one filter lane: signed MAC with round/saturate/ReLU result register
module mac_lane
    import conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     acc_en,
    input  logic                     fin,
    input  logic                     relu,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] sample,
    output logic        [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc;
    logic signed [DATA_W-1:0]   rounded;
    logic        [DATA_W-1:0]   result_d;

    always_comb begin
        prod     = weight * sample;
        prod_ext = ACC_W'(prod);
        // Truncation is safe: sat_round already clamped into the DATA_W range.
        rounded  = DATA_W'(sat_round(64'(acc), FRAC, DATA_W));
        result_d = (relu && rounded[DATA_W-1]) ? '0 : rounded;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (load) begin
                acc <= prod_ext;
            end else if (acc_en) begin
                acc <= acc + prod_ext;
            end
            if (fin) begin
                result <= result_d;
            end
        end
    end

endmodule

// File: rtl/conv_mac_engine.sv
// rtl/conv_mac_engine.sv - weight bank, window FSM and handshakes around N_FILT MAC lanes
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FRAC    = 8,
    parameter int KERNEL  = 9,
    parameter int N_CH    = 3,
    parameter int N_FILT  = 3,
    parameter int ACC_W   = 40,
    localparam int LANE_WIN = N_CH * KERNEL,
    localparam int N_W      = N_FILT * LANE_WIN,
    localparam int AW       = (clog2(N_W) > 0) ? clog2(N_W) : 1,
    localparam int KW       = (clog2(LANE_WIN) > 0) ? clog2(LANE_WIN) : 1
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic                     clear,
    input  logic                     w_we,
    input  logic [AW-1:0]            w_addr,
    input  logic [DATA_W-1:0]        w_data,
    output logic                     wr_drop,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_FILT*DATA_W-1:0] out_data,
    output logic                     busy
);

    state_t            state;
    logic [KW-1:0]     k;
    logic              relu_q;
    logic [DATA_W-1:0] wbank [N_W];

    logic hs_in;
    logic w_ok;
    logic last_k;
    logic lane_load;
    logic lane_acc;
    logic lane_fin;
    logic lane_clear;

    always_comb begin
        in_ready   = (state == IDLE) || (state == ACC);
        busy       = (state != IDLE);
        hs_in      = in_valid && in_ready;
        last_k     = (k == KW'(LANE_WIN - 1));
        w_ok       = (state == IDLE) && (int'(w_addr) < N_W);
        lane_load  = hs_in && (state == IDLE) && !clear;
        lane_acc   = hs_in && (state == ACC) && !clear;
        lane_fin   = (state == FIN) && !clear;
        lane_clear = clear || ((state == OUT) && out_ready);
    end

    // Writes commit at the edge, so a sample taken in the same IDLE cycle reads the old weight.
    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < N_W; i++) begin
                wbank[i] <= '0;
            end
            wr_drop <= 1'b0;
        end else begin
            if (w_we && w_ok) begin
                wbank[w_addr] <= w_data;
            end
            wr_drop <= w_we && !w_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state     <= IDLE;
            k         <= '0;
            out_valid <= 1'b0;
            relu_q    <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            k         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs_in) begin
                        relu_q <= relu_en;
                        if (last_k) begin
                            state <= FIN;
                            k     <= '0;
                        end else begin
                            state <= ACC;
                            k     <= k + 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (hs_in) begin
                        if (last_k) begin
                            state <= FIN;
                            k     <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                FIN: begin
                    state     <= OUT;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    k         <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar f = 0; f < N_FILT; f++) begin : g_lane
        logic [DATA_W-1:0] lane_w;
        logic [DATA_W-1:0] lane_res;

        always_comb begin
            lane_w = wbank[AW'(f * LANE_WIN + int'(k))];
        end

        mac_lane #(
            .DATA_W (DATA_W),
            .FRAC   (FRAC),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk    (clk),
            .RESET  (RESET),
            .clear  (lane_clear),
            .load   (lane_load),
            .acc_en (lane_acc),
            .fin    (lane_fin),
            .relu   (relu_q),
            .weight (lane_w),
            .sample (in_data),
            .result (lane_res)
        );

        assign out_data[f*DATA_W +: DATA_W] = lane_res;
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb/tb_conv_mac_engine.sv - directed self-checking bench for conv_mac_engine
module tb_conv_mac_engine;

    localparam logic [47:0] EXP_POS  = {3{16'h1B00}};
    localparam logic [47:0] EXP_NEG  = {3{16'hE500}};
    localparam logic [47:0] EXP_PSAT = {3{16'h7FFF}};
    localparam logic [47:0] EXP_NSAT = {3{16'h8000}};
    localparam logic [47:0] EXP_L0   = {16'h1B00, 16'h1B00, 16'h1A00};

    logic        clk;
    logic        RESET;
    logic        clear;
    logic        w_we;
    logic [6:0]  w_addr;
    logic [15:0] w_data;
    logic        wr_drop;
    logic        relu_en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic        busy;

    int tests_run;
    int tests_failed;

    conv_mac_engine dut (
        .clk       (clk),
        .RESET     (RESET),
        .clear     (clear),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .wr_drop   (wr_drop),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int addr, input logic [15:0] d);
        w_we   = 1'b1;
        w_addr = 7'(addr);
        w_data = d;
        tick();
        w_we   = 1'b0;
    endtask

    task automatic write_all(input logic [15:0] d);
        for (int i = 0; i < 81; i++) begin
            write_w(i, d);
        end
    endtask

    task automatic stream(input int n, input logic [15:0] d, input logic relu_first);
        in_valid = 1'b1;
        in_data  = d;
        relu_en  = relu_first;
        for (int i = 0; i < n; i++) begin
            tick();
            relu_en = 1'b0;
        end
        in_valid = 1'b0;
        in_data  = 16'h5A5A;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: out_valid=%b busy=%b wr_drop=%b required 0 0 0", out_valid, busy, wr_drop);
        end
        tests_run++;
        if (out_data !== 48'h0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_data: out_data=%h in_ready=%b required 0 1", out_data, in_ready);
        end
    endtask

    task automatic test_basic;
        write_all(16'h0100);
        out_ready = 1'b1;
        stream(27, 16'h0100, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_latency: valid=%b in_ready=%b required 0 0", out_valid, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== EXP_POS) begin
            tests_failed++;
            $display("FAIL basic_result: valid=%b data=%h required 1 %h", out_valid, out_data, EXP_POS);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_return: valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_relu;
        write_all(16'hFF00);
        stream(27, 16'h0100, 1'b0);
        tick();
        tests_run++;
        if (out_data !== EXP_NEG) begin
            tests_failed++;
            $display("FAIL negative: data=%h required %h", out_data, EXP_NEG);
        end
        tick();
        stream(27, 16'h0100, 1'b1);
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 48'h0) begin
            tests_failed++;
            $display("FAIL relu: valid=%b data=%h required 1 0", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_saturation;
        write_all(16'h7FFF);
        stream(27, 16'h7FFF, 1'b0);
        tick();
        tests_run++;
        if (out_data !== EXP_PSAT) begin
            tests_failed++;
            $display("FAIL sat_pos: data=%h required %h", out_data, EXP_PSAT);
        end
        tick();
        write_all(16'h8000);
        stream(27, 16'h7FFF, 1'b0);
        tick();
        tests_run++;
        if (out_data !== EXP_NSAT) begin
            tests_failed++;
            $display("FAIL sat_neg: data=%h required %h", out_data, EXP_NSAT);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        write_all(16'h0100);
        out_ready = 1'b0;
        stream(27, 16'h0100, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== EXP_POS) begin
                tests_failed++;
                $display("FAIL backpressure_%0d: valid=%b in_ready=%b data=%h required 1 0 %h",
                         i, out_valid, in_ready, out_data, EXP_POS);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_handshake: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        stream(27, 16'h0100, 1'b0);
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== EXP_POS) begin
            tests_failed++;
            $display("FAIL b2b_second: valid=%b data=%h required 1 %h", out_valid, out_data, EXP_POS);
        end
        tick();
    endtask

    task automatic test_wr_drop;
        stream(5, 16'h0100, 1'b0);
        write_w(0, 16'h0000);
        tests_run++;
        if (wr_drop !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_busy: wr_drop=%b required 1", wr_drop);
        end
        tick();
        tests_run++;
        if (wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_pulse: wr_drop=%b required 0", wr_drop);
        end
        stream(22, 16'h0100, 1'b0);
        tick();
        tests_run++;
        if (out_data !== EXP_POS) begin
            tests_failed++;
            $display("FAIL drop_busy_result: data=%h required %h", out_data, EXP_POS);
        end
        tick();
        write_w(81, 16'h0000);
        tests_run++;
        if (wr_drop !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_range: wr_drop=%b required 1", wr_drop);
        end
        tick();
        tests_run++;
        if (wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_range_pulse: wr_drop=%b required 0", wr_drop);
        end
        w_we     = 1'b1;
        w_addr   = 7'd0;
        w_data   = 16'h0000;
        in_valid = 1'b1;
        in_data  = 16'h0100;
        tick();
        w_we = 1'b0;
        tests_run++;
        if (wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_cycle_drop: wr_drop=%b required 0", wr_drop);
        end
        stream(26, 16'h0100, 1'b0);
        tick();
        tests_run++;
        if (out_data !== EXP_POS) begin
            tests_failed++;
            $display("FAIL same_cycle_old_weight: data=%h required %h", out_data, EXP_POS);
        end
        tick();
        stream(27, 16'h0100, 1'b0);
        tick();
        tests_run++;
        if (out_data !== EXP_L0) begin
            tests_failed++;
            $display("FAIL same_cycle_new_weight: data=%h required %h", out_data, EXP_L0);
        end
        tick();
        write_w(0, 16'h0100);
    endtask

    task automatic test_clear;
        stream(10, 16'h0100, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_state: busy=%b valid=%b required 0 0", busy, out_valid);
        end
        stream(27, 16'h0100, 1'b0);
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== EXP_POS) begin
            tests_failed++;
            $display("FAIL clear_residue: valid=%b data=%h required 1 %h", out_valid, out_data, EXP_POS);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        stream(10, 16'h0100, 1'b0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tests_run++;
        if (out_data !== 48'h0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_state: data=%h busy=%b valid=%b required 0 0 0", out_data, busy, out_valid);
        end
        stream(27, 16'h0100, 1'b0);
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_weights: valid=%b data=%h required 1 0", out_valid, out_data);
        end
        tick();
    endtask

    initial begin
        clk          = 1'b0;
        RESET        = 1'b1;
        clear        = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;
        w_data       = '0;
        relu_en      = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b1;
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_back_to_back();
        test_wr_drop();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
